// File: rtl/vote_input_debounce_pkg.sv
// Shared types for the voter front end: the {x,y,z} vote word and the
// snapshot handshake states.
package vote_pkg;

    localparam int VOTE_W = 3;

    // Bit order is {x,y,z}: [2]=x, [1]=y, [0]=z
    typedef logic [VOTE_W-1:0] vote_t;

    typedef enum logic {
        SNAP_EMPTY,
        SNAP_FULL
    } snap_state_t;

endpackage

// File: rtl/vote_input_debounce_channel.sv
// One switch channel: 2-FF synchroniser, mismatch counter and stable level.
// o_commit pulses for the single cycle in which a new level is accepted;
// o_next is the level the stable bit takes at the end of this cycle.
module debounce_channel #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_next,
    output logic o_commit,
    output logic o_busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;
    logic             w_commit;

    assign w_mismatch = r_sync2 ^ r_stable;
    assign w_commit   = w_mismatch && (r_cnt == CNT_LAST);

    // Two-stage synchroniser; nothing downstream looks at i_async directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= RESET_BIT;
            r_sync2 <= RESET_BIT;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive mismatch cycles; accept the synced level on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= RESET_BIT;
        end else if (!w_mismatch) begin
            r_cnt <= '0;
        end else if (w_commit) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_level  = r_stable;
    assign o_next   = w_commit ? r_sync2 : r_stable;
    assign o_commit = w_commit;
    assign o_busy   = |r_cnt;

endmodule

// File: rtl/vote_input_debounce.sv
// Voter front end: three debounced switch channels feeding x/y/z, plus a
// one-deep valid/ready snapshot of every accepted change with a sticky
// overrun flag. Optional feature macro: EDGE_COUNT_EN adds commit_count[7:0].
module vote_input_debounce
    import vote_pkg::*;
#(
    parameter int    DEBOUNCE_CYCLES = 16,
    parameter vote_t RESET_VAL       = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VOTE_W-1:0] sw_in,
    output logic              x,
    output logic              y,
    output logic              z,
    output logic [VOTE_W-1:0] snap_data,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic              overrun,
    output logic              busy
`ifdef EDGE_COUNT_EN
    ,
    output logic [7:0]        commit_count
`endif
);

    vote_t       w_level;
    vote_t       w_next;
    vote_t       w_commit;
    vote_t       w_busy;
    logic        w_any_commit;
    snap_state_t r_state;
    vote_t       r_snap_data;
    logic        r_overrun;

    for (genvar g = 0; g < VOTE_W; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VAL[g])
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_async  (sw_in[g]),
            .o_level  (w_level[g]),
            .o_next   (w_next[g]),
            .o_commit (w_commit[g]),
            .o_busy   (w_busy[g])
        );
    end

    // Simultaneous commits on several channels are a single event
    assign w_any_commit = |w_commit;

    // Snapshot holder: a commit with ready high is a pop and push in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SNAP_EMPTY;
            r_snap_data <= RESET_VAL;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                SNAP_EMPTY: begin
                    if (w_any_commit) begin
                        r_snap_data <= w_next;
                        r_state     <= SNAP_FULL;
                    end
                end
                SNAP_FULL: begin
                    if (w_any_commit) begin
                        r_snap_data <= w_next;
                        if (!snap_ready) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (snap_ready) begin
                        r_state <= SNAP_EMPTY;
                    end
                end
                default: r_state <= SNAP_EMPTY;
            endcase
        end
    end

`ifdef EDGE_COUNT_EN
    logic [7:0] r_commit_count;

    // Free-running count of commit events, wrapping at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_count <= '0;
        end else if (w_any_commit) begin
            r_commit_count <= r_commit_count + 8'd1;
        end
    end

    assign commit_count = r_commit_count;
`endif

    assign x          = w_level[2];
    assign y          = w_level[1];
    assign z          = w_level[0];
    assign snap_data  = r_snap_data;
    assign snap_valid = (r_state == SNAP_FULL);
    assign overrun    = r_overrun;
    assign busy       = |w_busy;

endmodule
